vending_machine_multi: RTL and testbench

- Parametrised successor to the single-coin toy dispenser.
- Accepts multi-denomination coins and accumulates credit against a configurable price.
- Dispenses one item per purchase, then returns any overpayment as unit change pulses.
- Sits between the coin-acceptor front end (coin value already decoded) and the dispense/change actuators.

---
 rtl/vending_machine_multi.sv | 123 ++++++++++++
 tb/tb_vending_machine_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// vending_machine_multi
//   Multi-denomination vending controller. Coins add to a credit register.
//   Once the credit reaches PRICE, one item is dispensed. Any overpayment is
//   then returned as one change pulse per credit unit.
//
//   Parameters:
//     PRICE    item price in credit units (1 .. 2**CREDIT_W-1)
//     CREDIT_W credit register width; the maximum credit is 2**CREDIT_W-1
//     COIN_W   coin value width; a coin value of 0 means no coin this cycle
//
//   Ports:
//     clock       rising-edge clock
//     reset       synchronous reset, active-low
//     coin        decoded coin value for this cycle (unsigned, 0 = none)
//     cancel      refund request (present only with VENDING_CANCEL_EN)
//     toy         dispense strobe, one cycle per purchase
//     change      change strobe, one cycle per credit unit returned
//     coin_reject high for one cycle after a coin that was not accepted
//     busy        high while the machine is not collecting coins
//     credit      current credit, for display and debug
//
//   Optional feature macro: VENDING_CANCEL_EN
//     When this macro is defined, the cancel port is added. A cancel in
//     COLLECT with non-zero credit refunds the whole credit through the
//     CHANGE state.
module vending_machine_multi #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int COIN_W   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [COIN_W-1:0]   coin,
`ifdef VENDING_CANCEL_EN
    input  logic                cancel,
`endif
    output logic                toy,
    output logic                change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        COLLECT  = 2'b00,
        DISPENSE = 2'b01,
        CHANGE   = 2'b10
    } state_t;

    localparam logic [CREDIT_W:0]   MAX_EXT   = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

    state_t              state;
    state_t              state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                rej_nxt;
    logic [CREDIT_W:0]   sum;

    // The extra bit lets an overflowing coin be detected instead of wrapping.
    assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin);

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        rej_nxt    = 1'b0;
        case (state)
            COLLECT: begin
`ifdef VENDING_CANCEL_EN
                // Cancel takes priority over a coin in the same cycle. That
                // coin is bounced back, and the whole credit drains as change.
                if (cancel && (credit != '0)) begin
                    state_nxt = CHANGE;
                    rej_nxt   = (coin != '0);
                end else
`endif
                if (coin != '0) begin
                    if (sum > MAX_EXT) begin
                        rej_nxt = 1'b1;
                    end else begin
                        credit_nxt = sum[CREDIT_W-1:0];
                        if (sum >= PRICE_EXT) state_nxt = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                credit_nxt = credit - PRICE_C;
                state_nxt  = (credit_nxt != '0) ? CHANGE : COLLECT;
                rej_nxt    = (coin != '0);
            end
            CHANGE: begin
                credit_nxt = credit - 1'b1;
                if (credit == CREDIT_W'(1)) state_nxt = COLLECT;
                rej_nxt    = (coin != '0);
            end
            default: begin
                state_nxt  = COLLECT;
                credit_nxt = '0;
            end
        endcase
    end

    // The outputs are registered from the next state, so each output matches
    // the state it reports in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= COLLECT;
            credit      <= '0;
            coin_reject <= 1'b0;
            toy         <= 1'b0;
            change      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            coin_reject <= rej_nxt;
            toy         <= (state_nxt == DISPENSE);
            change      <= (state_nxt == CHANGE);
            busy        <= (state_nxt != COLLECT);
        end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi
//   Directed bench for vending_machine_multi. It has two instances: one with
//   the default parameters (PRICE=3) and one with PRICE=15 to exercise the
//   full-credit boundary.
//   The status vectors are {toy, change, busy, coin_reject, credit[3:0]}.
module tb_vending_machine_multi;

    logic       clock;
    logic       reset;
    logic [1:0] coin;
    logic [1:0] coin15;
`ifdef VENDING_CANCEL_EN
    logic       cancel;
    logic       cancel15;
`endif
    logic       toy, change, coin_reject, busy;
    logic [3:0] credit;
    logic       toy15, change15, coin_reject15, busy15;
    logic [3:0] credit15;
    logic [7:0] obs, obs15;

    int vectors;
    int miscompares;
    int pulses;

    vending_machine_multi #(.PRICE(3), .CREDIT_W(4), .COIN_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .coin        (coin),
`ifdef VENDING_CANCEL_EN
        .cancel      (cancel),
`endif
        .toy         (toy),
        .change      (change),
        .coin_reject (coin_reject),
        .busy        (busy),
        .credit      (credit)
    );

    vending_machine_multi #(.PRICE(15), .CREDIT_W(4), .COIN_W(2)) dut15 (
        .clock       (clock),
        .reset       (reset),
        .coin        (coin15),
`ifdef VENDING_CANCEL_EN
        .cancel      (cancel15),
`endif
        .toy         (toy15),
        .change      (change15),
        .coin_reject (coin_reject15),
        .busy        (busy15),
        .credit      (credit15)
    );

    assign obs   = {toy, change, busy, coin_reject, credit};
    assign obs15 = {toy15, change15, busy15, coin_reject15, credit15};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        coin = 2'd0;
        coin15 = 2'd0;
        step();
        step();
        vectors++;
        if (obs !== 8'b0000_0000) begin
            miscompares++;
            $display("FAIL reset: got %b expected %b", obs, 8'b0000_0000);
        end
        vectors++;
        if (obs15 !== 8'b0000_0000) begin
            miscompares++;
            $display("FAIL reset15: got %b expected %b", obs15, 8'b0000_0000);
        end
        reset = 1'b1;
    endtask

    task automatic test_exact_price();
        logic [7:0] exp_tab [5] = '{8'b0000_0001, 8'b0000_0010, 8'b1010_0011,
                                    8'b0000_0000, 8'b0000_0000};
        logic [1:0] coin_tab [5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 5; i++) begin
            coin = coin_tab[i];
            step();
            vectors++;
            if (obs !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL exact_price[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
    endtask

    task automatic test_change();
        logic [7:0] exp_tab [5] = '{8'b0000_0010, 8'b1010_0101, 8'b0110_0010,
                                    8'b0110_0001, 8'b0000_0000};
        logic [1:0] coin_tab [5] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            coin = coin_tab[i];
            step();
            if (change === 1'b1) pulses++;
            vectors++;
            if (obs !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL change[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL change_pulses: got %0d expected %0d", pulses, 2);
        end
    endtask

    task automatic test_reject_during_change();
        logic [7:0] exp_tab [6] = '{8'b0000_0010, 8'b1010_0101, 8'b0110_0010,
                                    8'b0111_0001, 8'b0000_0000, 8'b0000_0000};
        logic [1:0] coin_tab [6] = '{2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            coin = coin_tab[i];
            step();
            if (change === 1'b1) pulses++;
            vectors++;
            if (obs !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL reject_in_change[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL reject_in_change_pulses: got %0d expected %0d", pulses, 2);
        end
    endtask

    task automatic test_reject_in_dispense();
        logic [7:0] exp_tab [3] = '{8'b1010_0011, 8'b0001_0000, 8'b0000_0000};
        logic [1:0] coin_tab [3] = '{2'd3, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            coin = coin_tab[i];
            step();
            vectors++;
            if (obs !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL reject_in_dispense[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
    endtask

    task automatic test_max_credit();
        logic [7:0] exp_tab [8] = '{8'b0000_0011, 8'b0000_0110, 8'b0000_1001,
                                    8'b0000_1100, 8'b0000_1110, 8'b0001_1110,
                                    8'b1010_1111, 8'b0000_0000};
        logic [1:0] coin_tab [8] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 2'd0};
        coin = 2'd0;
        for (int i = 0; i < 8; i++) begin
            coin15 = coin_tab[i];
            step();
            vectors++;
            if (obs15 !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL max_credit[%0d]: got %b expected %b", i, obs15, exp_tab[i]);
            end
        end
    endtask

    task automatic test_reset_mid_change();
        logic [7:0] exp_tab [5] = '{8'b0000_0010, 8'b1010_0101, 8'b0110_0010,
                                    8'b0000_0000, 8'b0000_0000};
        logic [1:0] coin_tab [5] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        logic       rst_tab  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            coin = coin_tab[i];
            reset = rst_tab[i];
            step();
            if (change === 1'b1) pulses++;
            vectors++;
            if (obs !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL reset_mid_change[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        reset = 1'b1;
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL reset_mid_change_pulses: got %0d expected %0d", pulses, 1);
        end
    endtask

`ifdef VENDING_CANCEL_EN
    task automatic test_cancel();
        logic [7:0] exp_tab [5] = '{8'b0000_0010, 8'b0111_0010, 8'b0110_0001,
                                    8'b0000_0000, 8'b0000_0000};
        logic [1:0] coin_tab [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        logic       can_tab  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            coin = coin_tab[i];
            cancel = can_tab[i];
            step();
            vectors++;
            if (obs !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL cancel[%0d]: got %b expected %b", i, obs, exp_tab[i]);
            end
        end
        cancel = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        pulses = 0;
`ifdef VENDING_CANCEL_EN
        cancel = 1'b0;
        cancel15 = 1'b0;
`endif
        test_reset();
        test_exact_price();
        test_change();
        test_reject_during_change();
        test_reject_in_dispense();
        test_max_credit();
        test_reset_mid_change();
`ifdef VENDING_CANCEL_EN
        test_cancel();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
